// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Command and response channels between an issuer and alu_issue_stage.
//   Command channel: cmd_valid/cmd_ready handshake carrying opcode,
//     destination, two source registers and an optional immediate.
//   Response channel: rsp_valid/rsp_ready handshake carrying the captured
//     ALU result and an illegal-opcode error bit.
//   master : the issuer (drives commands, accepts responses)
//   slave  : the issue stage
interface alu_issue_stage_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [2:0]       cmd_rd;
   logic [2:0]       cmd_rs1;
   logic [2:0]       cmd_rs2;
   logic             cmd_imm_en;
   logic [WIDTH-1:0] cmd_imm;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
      output rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
      input  rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_err
   );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Sequencing stage in front of a combinational 32-bit ALU. Owns an 8-entry
//   register file (R0 hard-wired to zero), issues one command at a time to
//   the ALU through registered operands, writes the result back, latches the
//   ALU flags of legal ops and returns the result on a response channel.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     bus (slave)       command / response handshake channels
//     load_en/addr/data direct register-file write, active in every state
//     alu_a/b/opcode    registered operands and opcode to the ALU
//     alu_result/flags  combinational ALU outputs
//     flags_q           {zero,neg,ovf,carry} of the last legal op
//     dbg_addr/dbg_data combinational register-file read
module alu_issue_stage #(
   parameter int unsigned NREGS = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_stage_if.slave bus,
   input  logic             load_en,
   input  logic [2:0]       load_addr,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_neg,
   input  logic             alu_ovf,
   input  logic             alu_carry,
   output logic [3:0]       flags_q,
   input  logic [2:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] rf [NREGS];
   logic [2:0]       rd_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_err_q;
   logic             accept;
   logic             in_exec;
   logic             op_legal;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs
   always_comb begin
      state_d       = state_q;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      accept        = 1'b0;
      in_exec       = 1'b0;
      case (state_q)
         IDLE: begin
            bus.cmd_ready = rst_n;
            accept        = bus.cmd_valid & rst_n;
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            in_exec = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign op_legal = (alu_opcode <= 3'd4);

   // Operand registers and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_opcode   <= '0;
         rd_q         <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
         flags_q      <= '0;
      end else begin
         if (accept) begin
            alu_a      <= rf[bus.cmd_rs1];
            alu_b      <= bus.cmd_imm_en ? bus.cmd_imm : rf[bus.cmd_rs2];
            alu_opcode <= bus.cmd_op;
            rd_q       <= bus.cmd_rd;
         end
         if (in_exec) begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= ~op_legal;
            if (op_legal) flags_q <= {alu_zero, alu_neg, alu_ovf, alu_carry};
         end
      end
   end

   // Register file. R0 is never written so it always reads zero.
   // The writeback assignment follows the load so it wins on a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         if (load_en && load_addr != 3'd0)
            rf[load_addr] <= load_data;
         if (in_exec && op_legal && rd_q != 3'd0)
            rf[rd_q] <= alu_result;
      end
   end

   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;
   assign dbg_data       = rf[dbg_addr];

endmodule
